mwadd_seq: RTL
==============

Name: mwadd_seq

Overview:
- Multi-word add sequencer sitting directly upstream of the team's N-bit clocked adder slice (fa32bit, N=4).
- Accepts a WORDS*N-bit operand pair and issues it to the slice one N-bit word at a time, LSW first.
- Chains each slice cout into the next word's cin and reassembles the wide sum and final carry.
- Lets a narrow adder perform a 32-bit add (default 8 x 4-bit).

Parameters:
- N, 4, slice width in bits (matches the adder's data width)
- WORDS, 8, number of slices per operand; total width W = N*WORDS
- LAT, 1, adder latency in clk edges from add_a/add_b/add_cin change to valid add_s/add_cout (0 = combinational)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op_a  in  W  operand A; latched on accepted start
- op_b  in  W  operand B; latched on accepted start
- cin_in  in  1  carry into word 0; latched on accepted start
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when result/cout_out are valid
- result  out  W  wide sum; holds until the next done
- cout_out  out  1  carry out of the top word
- add_a  out  N  current word of A to the adder (registered)
- add_b  out  N  current word of B to the adder (registered)
- add_cin  out  1  current carry to the adder (registered)
- add_s  in  N  adder sum
- add_cout  in  1  adder carry

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE; busy, done, cout_out, add_a, add_b, add_cin, result, word index, wait counter all 0.
- States:
  - IDLE: waits for start.
  - WAIT: counts adder latency.
  - No separate DONE state; done is a registered pulse.
- IDLE, start=1 at edge E0:
  - Latch op_a, op_b, cin_in.
  - add_a <= op_a[N-1:0], add_b <= op_b[N-1:0], add_cin <= cin_in.
  - idx <= 0, cnt <= 0, busy <= 1; go to WAIT.
- WAIT, each edge:
  - If cnt != LAT: cnt <= cnt+1.
  - If cnt == LAT (capture edge): result[idx*N +: N] <= add_s; carry <= add_cout.
    - If idx < WORDS-1: drive word idx+1 on add_a/add_b, add_cin <= add_cout, idx++, cnt <= 0.
    - If idx == WORDS-1: cout_out <= add_cout, done <= 1, busy <= 0; go to IDLE.
- Timing:
  - Each word takes exactly LAT+1 cycles.
  - done is high in the cycle after edge E0 + WORDS*(LAT+1); default config gives 16 cycles.
  - done is high for exactly one cycle, then cleared.
- Arithmetic: no truncation; result plus cout_out equals op_a + op_b + cin_in modulo 2^(W+1).
- start while busy: ignored, no queuing; latched operands are unaffected by op_a/op_b changes mid-operation.
- start in the same cycle done is high: state is IDLE, so start is accepted and a back-to-back operation begins.
- Partial results: result bits are written per word during the operation; only values read at done are defined.
- rst mid-operation: all state and outputs return to reset values on that edge; no done is produced.
- WORDS=1: a single capture, and done follows LAT+1 cycles after start.
- LAT=0: capture on the first edge after issue.

Optional Feature:
- Macro MWADD_SUB_EN adds an input port sub (1 bit), latched with the operands on an accepted start.
- sub=1:
  - Every issued add_b word is ~op_b word.
  - Word-0 add_cin is 1 (cin_in ignored), so result = op_a - op_b mod 2^W.
  - cout_out = 1 means no borrow.
- sub=0: identical to the base behaviour.
- Without the macro: no sub port; add-only behaviour.

Decomposition:
- Package mwadd_pkg holds:
  - state encoding constants (S_IDLE, S_WAIT)
  - function clog2 for cnt/idx widths
  - default N/WORDS/LAT constants
- Optional single sub-module mwadd_word_sel: combinational slice extractor (selects word idx from a W-bit vector, with optional inversion for subtract).
- The FSM stays in mwadd_seq.

Test Plan:
- The bench binds mwadd_seq to the team's fa32bit slice (N=4) with LAT set to that slice's latency.
- A bench-side model with configurable LAT covers LAT=0 and LAT=2.
- Scenarios:
  1. Basic add: op_a=32'h0000_0003, op_b=32'h0000_0005, cin_in=0 -> done after 8*(LAT+1) cycles, result=32'h0000_0008, cout_out=0; busy high throughout.
  2. Full carry ripple: op_a=32'hFFFF_FFFF, op_b=32'h0000_0001 -> result=32'h0000_0000, cout_out=1; add_cin=1 on words 1..7.
  3. Carry in: op_a=32'h7FFF_FFFF, op_b=0, cin_in=1 -> result=32'h8000_0000, cout_out=0.
  4. Start while busy with new operands 32'h1/32'h1 -> ignored, original result delivered; start on the done cycle -> second op accepted, done again exactly 8*(LAT+1) cycles later.
  5. rst asserted at word 3 -> next cycle busy=0, done=0, result=0, add_* = 0; no done pulse follows.
  6. MWADD_SUB_EN, sub=1: op_a=32'h0000_0005, op_b=32'h0000_0007 -> result=32'hFFFF_FFFE, cout_out=0; op_a=9, op_b=4 -> result=5, cout_out=1.

Source files
------------

// File: rtl/mwadd_pkg.sv
// Shared definitions for the multi-word add sequencer.
//   - state_e : sequencer FSM state encoding (S_IDLE, S_WAIT)
//   - clog2   : ceiling log2 used to size the word index and latency counter
//   - N_DEF / WORDS_DEF / LAT_DEF : default slice width, word count, adder latency
package mwadd_pkg;

  localparam int N_DEF     = 4;
  localparam int WORDS_DEF = 8;
  localparam int LAT_DEF   = 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mwadd_word_sel.sv
// Combinational word extractor: picks N-bit word idx out of a WORDS*N-bit
// vector and optionally inverts it (one's complement for subtraction).
// Ports:
//   vec  in  WORDS*N  source vector
//   idx  in  IDX_W    word index (0 = least significant word)
//   inv  in  1        invert the selected word
//   word out N        selected (and optionally inverted) word
module mwadd_word_sel
  import mwadd_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WORDS = WORDS_DEF,
  parameter int IDX_W = (WORDS > 1) ? clog2(WORDS) : 1
) (
  input  logic [N*WORDS-1:0] vec,
  input  logic [IDX_W-1:0]   idx,
  input  logic               inv,
  output logic [N-1:0]       word
);

  assign word = vec[idx*N +: N] ^ {N{inv}};

endmodule

// File: rtl/mwadd_seq.sv
// Multi-word add sequencer. Feeds a WORDS*N-bit operand pair to an N-bit
// clocked adder slice one word at a time (LSW first), chains the slice carry
// into the next word, and reassembles the wide sum and final carry.
// Optional build macro: MWADD_SUB_EN adds the 'sub' input (A - B when set).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request, sampled only while idle
//   op_a, op_b, cin_in  operands and carry-in, latched on accepted start
//   sub               (MWADD_SUB_EN only) subtract request, latched on start
//   busy              operation in flight
//   done              one-cycle pulse when result/cout_out are valid
//   result, cout_out  wide sum and carry out of the top word
//   add_a, add_b, add_cin  registered word/carry driven to the adder slice
//   add_s, add_cout   adder slice sum and carry
module mwadd_seq
  import mwadd_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WORDS = WORDS_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N*WORDS-1:0]  op_a,
  input  logic [N*WORDS-1:0]  op_b,
  input  logic                cin_in,
`ifdef MWADD_SUB_EN
  input  logic                sub,
`endif
  output logic                busy,
  output logic                done,
  output logic [N*WORDS-1:0]  result,
  output logic                cout_out,
  output logic [N-1:0]        add_a,
  output logic [N-1:0]        add_b,
  output logic                add_cin,
  input  logic [N-1:0]        add_s,
  input  logic                add_cout
);

  localparam int W     = N * WORDS;
  localparam int IDX_W = (WORDS > 1) ? clog2(WORDS) : 1;
  localparam int CNT_W = (LAT > 0) ? clog2(LAT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CAP_CNT  = CNT_W'(LAT);

  state_e           state_q, state_d;
  logic [W-1:0]     opa_q, opa_d;
  logic [W-1:0]     opb_q, opb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic [N-1:0]     add_a_q, add_a_d;
  logic [N-1:0]     add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;

  logic             sub_start;
  logic             inv_b;
  logic [IDX_W-1:0] nxt_idx;
  logic [N-1:0]     nxt_a, nxt_b;

`ifdef MWADD_SUB_EN
  logic sub_q, sub_d;
  assign sub_start = sub;
  assign inv_b     = sub_q;
`else
  assign sub_start = 1'b0;
  assign inv_b     = 1'b0;
`endif

  // Wraps to 0 after the last word; only consumed while more words remain.
  assign nxt_idx = idx_q + 1'b1;

  mwadd_word_sel #(.N(N), .WORDS(WORDS), .IDX_W(IDX_W)) u_sel_a (
    .vec  (opa_q),
    .idx  (nxt_idx),
    .inv  (1'b0),
    .word (nxt_a)
  );

  mwadd_word_sel #(.N(N), .WORDS(WORDS), .IDX_W(IDX_W)) u_sel_b (
    .vec  (opb_q),
    .idx  (nxt_idx),
    .inv  (inv_b),
    .word (nxt_b)
  );

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    cout_d    = cout_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;
`ifdef MWADD_SUB_EN
    sub_d     = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d     = op_a;
          opb_d     = op_b;
`ifdef MWADD_SUB_EN
          sub_d     = sub;
`endif
          add_a_d   = op_a[N-1:0];
          add_b_d   = op_b[N-1:0] ^ {N{sub_start}};
          // Subtraction is A + ~B + 1, so word 0 carries in a forced 1.
          add_cin_d = sub_start | cin_in;
          idx_d     = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != CAP_CNT) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Adder output for the current word is valid on this edge.
          result_d[idx_q*N +: N] = add_s;
          if (idx_q != LAST_IDX) begin
            add_a_d   = nxt_a;
            add_b_d   = nxt_b;
            add_cin_d = add_cout;
            idx_d     = nxt_idx;
            cnt_d     = '0;
          end else begin
            cout_d  = add_cout;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
`ifdef MWADD_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
`ifdef MWADD_SUB_EN
      sub_q     <= sub_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout_out = cout_q;
  assign add_a    = add_a_q;
  assign add_b    = add_b_q;
  assign add_cin  = add_cin_q;

endmodule
